// File: rtl/fpaddsub_prealign_pipe.sv
// Pre-alignment for FP add/sub: unpack, classify, order operands, saturated alignment shift.
// Latency 2 cycles (S1 decode/diff, S2 swap/shift); throughput one op per cycle.
// Backpressure: stage k loads when empty or next stage loads; in_ready is combinational from out_ready.
// Optional build macro FPADDSUB_DENORM_EN: keep denormals (hidden 0, exponent 1); otherwise flush to zero.
module fpaddsub_prealign_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int SHIFT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   operation,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_s_big,
  output logic                   out_eff_sub,
  output logic                   out_swap,
  output logic [EXP_W-1:0]       out_exp_big,
  output logic [MAN_W:0]         out_man_big,
  output logic [MAN_W:0]         out_man_small,
  output logic [SHIFT_W-1:0]     out_shift,
  output logic [4:0]             out_exc,
  output logic [1:0]             out_zero
);

  // Largest useful right shift: full mantissa plus guard/round/sticky.
  localparam logic [EXP_W:0] SHIFT_SAT = (EXP_W+1)'(MAN_W+3);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;   // effective exponent
    logic [MAN_W:0]   man;   // mantissa with hidden bit
    logic             nan;
    logic             inf;
    logic             zero;
  } unp_t;

  typedef struct packed {
    logic             s_a;
    logic             s_b;   // already flipped by operation
    logic             eff_sub;
    logic [EXP_W-1:0] e_a;
    logic [EXP_W-1:0] e_b;
    logic [MAN_W:0]   m_a;
    logic [MAN_W:0]   m_b;
    logic [EXP_W:0]   diff;  // signed e_a - e_b, one extra bit so it never wraps
    logic [4:0]       exc;
    logic [1:0]       zero;
  } s1_t;

  typedef struct packed {
    logic               s_big;
    logic               eff_sub;
    logic               swap;
    logic [EXP_W-1:0]   exp_big;
    logic [MAN_W:0]     man_big;
    logic [MAN_W:0]     man_small;
    logic [SHIFT_W-1:0] shift;
    logic [4:0]         exc;
    logic [1:0]         zero;
  } s2_t;

  // Split one operand into fields; exception flags look at the raw encoding.
  function automatic unp_t unpack(input logic [EXP_W+MAN_W:0] x);
    unp_t             u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             ez;
    logic             mz;
    e      = x[MAN_W +: EXP_W];
    m      = x[MAN_W-1:0];
    ez     = (e == '0);
    mz     = (m == '0);
    u.sign = x[EXP_W+MAN_W];
    u.nan  = (&e) & ~mz;
    u.inf  = (&e) & mz;
`ifdef FPADDSUB_DENORM_EN
    u.exp  = (ez && !mz) ? EXP_W'(1) : e;
    u.man  = {~ez, m};
    u.zero = ez & mz;
`else
    u.exp  = e;
    u.man  = ez ? '0 : {1'b1, m};
    u.zero = ez;
`endif
    return u;
  endfunction

  logic  v1, v2;
  logic  en1, en2;
  unp_t  ua, ub;
  s1_t   d1, r1;
  s2_t   d2, r2;
  logic [EXP_W:0] absdiff;

  assign en2      = ~v2 | out_ready;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;

  // S1 next value: decode both operands, exceptions and exponent difference.
  always_comb begin
    ua         = unpack(a);
    ub         = unpack(b);
    d1         = '0;
    d1.s_a     = ua.sign;
    d1.s_b     = ub.sign ^ operation;
    d1.eff_sub = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W] ^ operation;
    d1.e_a     = ua.exp;
    d1.e_b     = ub.exp;
    d1.m_a     = ua.man;
    d1.m_b     = ub.man;
    d1.diff    = {1'b0, ua.exp} - {1'b0, ub.exp};
    d1.exc     = {ua.nan | ub.nan | ua.inf | ub.inf, ua.nan, ub.nan, ua.inf, ub.inf};
    d1.zero    = {ua.zero, ub.zero};
  end

  // S2 next value: order by magnitude and saturate the alignment shift.
  always_comb begin
    d2           = '0;
    d2.swap      = r1.diff[EXP_W] | ((r1.diff == '0) & (r1.m_b > r1.m_a));
    absdiff      = r1.diff[EXP_W] ? -r1.diff : r1.diff;
    d2.shift     = SHIFT_W'((absdiff > SHIFT_SAT) ? SHIFT_SAT : absdiff);
    d2.s_big     = d2.swap ? r1.s_b : r1.s_a;
    d2.eff_sub   = r1.eff_sub;
    d2.exp_big   = d2.swap ? r1.e_b : r1.e_a;
    d2.man_big   = d2.swap ? r1.m_b : r1.m_a;
    d2.man_small = d2.swap ? r1.m_a : r1.m_b;
    d2.exc       = r1.exc;
    d2.zero      = r1.zero;
  end

  // S1 register: accept a new op whenever the slot is free or drains this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) r1 <= d1;
    end
  end

  // S2 register: holds its result while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      r2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) r2 <= d2;
    end
  end

  // Outputs read as zero whenever nothing valid is presented.
  assign out_valid     = v2;
  assign out_s_big     = v2 & r2.s_big;
  assign out_eff_sub   = v2 & r2.eff_sub;
  assign out_swap      = v2 & r2.swap;
  assign out_exp_big   = v2 ? r2.exp_big   : '0;
  assign out_man_big   = v2 ? r2.man_big   : '0;
  assign out_man_small = v2 ? r2.man_small : '0;
  assign out_shift     = v2 ? r2.shift     : '0;
  assign out_exc       = v2 ? r2.exc       : '0;
  assign out_zero      = v2 ? r2.zero      : '0;

endmodule

// File: tb/tb_fpaddsub_prealign_pipe.sv
// Directed bench for fpaddsub_prealign_pipe with a small in-order scoreboard.
// Expected outputs are hand-computed per vector; latency, stall hold and reset are checked too.
// Build with FPADDSUB_DENORM_EN defined or not; the denormal vector picks its expectation to match.
module tb_fpaddsub_prealign_pipe;

  typedef struct packed {
    logic        s_big;
    logic        eff_sub;
    logic        swap;
    logic [7:0]  exp_big;
    logic [23:0] man_big;
    logic [23:0] man_small;
    logic [4:0]  shift;
    logic [4:0]  exc;
    logic [1:0]  zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        operation;
  logic        out_valid;
  logic        out_ready;
  logic        out_s_big, out_eff_sub, out_swap;
  logic [7:0]  out_exp_big;
  logic [23:0] out_man_big, out_man_small;
  logic [4:0]  out_shift, out_exc;
  logic [1:0]  out_zero;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  int          qid[$];
  logic [31:0] va[10], vb[10];
  logic        vop[10];
  exp_t        ve[10];
  exp_t        cur, prev, e;
  int          id;
  logic        prev_stall = 1'b0;

  fpaddsub_prealign_pipe #(.EXP_W(8), .MAN_W(23), .SHIFT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s_big(out_s_big), .out_eff_sub(out_eff_sub), .out_swap(out_swap),
    .out_exp_big(out_exp_big), .out_man_big(out_man_big), .out_man_small(out_man_small),
    .out_shift(out_shift), .out_exc(out_exc), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic s_big, input logic eff_sub, input logic swap,
                              input logic [7:0] exp_big, input logic [23:0] man_big,
                              input logic [23:0] man_small, input logic [4:0] shift,
                              input logic [4:0] exc, input logic [1:0] zero);
    exp_t r;
    r = {s_big, eff_sub, swap, exp_big, man_big, man_small, shift, exc, zero};
    return r;
  endfunction

  task automatic cmp(input int vid, input exp_t x);
    check($sformatf("v%0d_s_big", vid),     out_s_big,     x.s_big);
    check($sformatf("v%0d_eff_sub", vid),   out_eff_sub,   x.eff_sub);
    check($sformatf("v%0d_swap", vid),      out_swap,      x.swap);
    check($sformatf("v%0d_exp_big", vid),   out_exp_big,   x.exp_big);
    check($sformatf("v%0d_man_big", vid),   out_man_big,   x.man_big);
    check($sformatf("v%0d_man_small", vid), out_man_small, x.man_small);
    check($sformatf("v%0d_shift", vid),     out_shift,     x.shift);
    check($sformatf("v%0d_exc", vid),       out_exc,       x.exc);
    check($sformatf("v%0d_zero", vid),      out_zero,      x.zero);
  endtask

  // Present one vector until accepted; record its expectation at the transfer.
  task automatic send(input int idx);
    int tries;
    tries     = 0;
    in_valid  = 1'b1;
    a         = va[idx];
    b         = vb[idx];
    operation = vop[idx];
    @(negedge clk);
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    else begin
      q.push_back(ve[idx]);
      qid.push_back(idx);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  // Output monitor: in-order scoreboard plus hold-stable check under stall.
  always @(negedge clk) begin
    cur = {out_s_big, out_eff_sub, out_swap, out_exp_big, out_man_big, out_man_small,
           out_shift, out_exc, out_zero};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_data_held", cur, prev);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else begin
          e  = q.pop_front();
          id = qid.pop_front();
          cmp(id, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = 32'h40400000; vb[0] = 32'h3F800000; vop[0] = 1'b0;
    ve[0] = mk(0, 0, 0, 8'h80, 24'hC00000, 24'h800000, 5'd1, 5'b00000, 2'b00);
    va[1] = 32'h3F800000; vb[1] = 32'hC0400000; vop[1] = 1'b1;
    ve[1] = mk(0, 0, 1, 8'h80, 24'hC00000, 24'h800000, 5'd1, 5'b00000, 2'b00);
    va[2] = 32'h4B800000; vb[2] = 32'h3F800000; vop[2] = 1'b0;
    ve[2] = mk(0, 0, 0, 8'h97, 24'h800000, 24'h800000, 5'd24, 5'b00000, 2'b00);
    va[3] = 32'h64000000; vb[3] = 32'h3F800000; vop[3] = 1'b1;
    ve[3] = mk(0, 1, 0, 8'hC8, 24'h800000, 24'h800000, 5'd26, 5'b00000, 2'b00);
    va[4] = 32'h3F800000; vb[4] = 32'hE4000000; vop[4] = 1'b0;
    ve[4] = mk(1, 1, 1, 8'hC8, 24'h800000, 24'h800000, 5'd26, 5'b00000, 2'b00);
    va[5] = 32'h00000000; vb[5] = 32'h7F800000; vop[5] = 1'b0;
    ve[5] = mk(0, 0, 1, 8'hFF, 24'h800000, 24'h000000, 5'd26, 5'b10001, 2'b10);
    va[6] = 32'h7FC00000; vb[6] = 32'h7F800000; vop[6] = 1'b0;
    ve[6] = mk(0, 0, 0, 8'hFF, 24'hC00000, 24'h800000, 5'd0, 5'b11001, 2'b00);
    va[7] = 32'h3F800000; vb[7] = 32'h3FC00000; vop[7] = 1'b0;
    ve[7] = mk(0, 0, 1, 8'h7F, 24'hC00000, 24'h800000, 5'd0, 5'b00000, 2'b00);
    va[8] = 32'h3F800000; vb[8] = 32'hBF800000; vop[8] = 1'b0;
    ve[8] = mk(0, 1, 0, 8'h7F, 24'h800000, 24'h800000, 5'd0, 5'b00000, 2'b00);
    va[9] = 32'h00000001; vb[9] = 32'h00000000; vop[9] = 1'b0;
`ifdef FPADDSUB_DENORM_EN
    ve[9] = mk(0, 0, 0, 8'h01, 24'h000001, 24'h000000, 5'd1, 5'b00000, 2'b01);
`else
    ve[9] = mk(0, 0, 0, 8'h00, 24'h000000, 24'h000000, 5'd0, 5'b00000, 2'b11);
`endif

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; operation = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_man_big", out_man_big, 24'h0);
    check("rst_exc", out_exc, 5'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    // Latency: accepted at one edge, valid after the second edge.
    send(0);
    check("lat_cycle1_idle", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", out_valid, 1'b1);
    drain();

    // Back-to-back stream with out_ready high.
    for (int i = 1; i < 9; i++) send(i);
    drain();

    // Backpressure: four back-to-back inputs while the consumer stalls.
    fork
      begin
        for (int i = 0; i < 4; i++) send(i);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream drops in-flight ops immediately.
    send(0);
    send(1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_man_big", out_man_big, 24'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    q.delete();
    qid.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Denormal handling (configuration dependent expectation).
    send(9);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
